// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the write-back register file: bus widths, enable
// polarities, the zero word / NOP register address and the FSM state type.
package regfile_wb_pkg;

    localparam int REG_BUS      = 32;   // register width
    localparam int REG_ADDR_BUS = 5;    // register address width
    localparam int REG_NUM      = 32;   // architectural register count

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

    localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;

    // INIT clears r1..r31 one per cycle; READY serves normal traffic.
    typedef enum logic {
        ST_INIT,
        ST_READY
    } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational operand read port of the register file. Applies the
// output-gating priority chain: busy, port disabled, r0, write-through
// bypass from the write-back stage, then the stored value.
module regfile_rd_port
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_ADDR_BUS
) (
    input  logic              rst,
    input  logic              init_busy,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] rdata
);

    // Priority read mux; earlier conditions mask later ones.
    always_comb begin
        rdata = DATA_W'(ZERO_WORD);
        if (rst == RST_ENABLE || init_busy) begin
            rdata = DATA_W'(ZERO_WORD);
        end else if (re != READ_ENABLE) begin
            rdata = DATA_W'(ZERO_WORD);
        end else if (raddr == ADDR_W'(NOP_REG_ADDR)) begin
            rdata = DATA_W'(ZERO_WORD);
        end else if (we == WRITE_ENABLE && waddr == raddr) begin
            rdata = wdata;
        end else begin
            rdata = reg_data;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Write-back-side general register file for the 5-stage MIPS pipeline.
// Two combinational read ports, one write port, and a post-reset sweep that
// clears r1..r31 while init_busy holds the pipeline off.
// Optional build macro REGFILE_DBG_PORT_EN adds a non-bypassed debug read
// port (dbg_addr / dbg_data).
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = REG_BUS,
    parameter int ADDR_W = REG_ADDR_BUS,
    parameter int NREGS  = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    logic [DATA_W-1:0] mem [NREGS];
    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              rst_act;
    logic              sweep_we;
    logic              ext_we;

    assign rst_act   = (rst == RST_ENABLE);
    assign init_busy = rst_act || (state == ST_INIT);
    assign sweep_we  = !rst_act && (state == ST_INIT);
    assign ext_we    = !rst_act && (state == ST_READY) && (we == WRITE_ENABLE)
                       && (waddr != ADDR_W'(NOP_REG_ADDR));

    // State register and sweep pointer; reset restarts the sweep at r1.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst_act) begin
            state <= ST_INIT;
            ptr   <= ADDR_W'(1);
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Next-state logic: leave INIT once the last register has been cleared.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            ST_INIT:  if (ptr == ADDR_W'(NREGS - 1)) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Storage writes: the clear sweep during INIT, external writes in READY.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the sweep clears it instead,
        // and the read muxes hide the contents until the sweep has finished.
        if (sweep_we) begin
            mem[ptr] <= DATA_W'(ZERO_WORD);
        end else if (ext_we) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
        .rst       (rst),
        .init_busy (init_busy),
        .re        (re1),
        .raddr     (raddr1),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .reg_data  (mem[raddr1]),
        .rdata     (rdata1)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
        .rst       (rst),
        .init_busy (init_busy),
        .re        (re2),
        .raddr     (raddr2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .reg_data  (mem[raddr2]),
        .rdata     (rdata2)
    );

`ifdef REGFILE_DBG_PORT_EN
    // Debug read: raw stored value, masked during reset/sweep and for r0.
    assign dbg_data = (init_busy || dbg_addr == ADDR_W'(NOP_REG_ADDR))
                      ? DATA_W'(ZERO_WORD) : mem[dbg_addr];
`else
    // No debug read path in this build.
`endif

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-back-side general register file for the 5-stage MIPS pipeline.
- Receives the write-back stage's register write: address, enable and data.
- Serves the two operand read ports used by the decode stage.
- After reset, an internal sweep clears r1..r31 before normal operation; a ready/busy indication lets the pipeline hold off until the sweep completes.

Parameters:
- DATA_W, 32, register width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- NREGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high (RstEnable = 1)
- we  in  1  write enable from write-back stage
- waddr  in  ADDR_W  write register address
- wdata  in  DATA_W  write data
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data (combinational)
- re2  in  1  read port 2 enable
- raddr2  in  ADDR_W  read port 2 address
- rdata2  out  DATA_W  read port 2 data (combinational)
- init_busy  out  1  high while reset is asserted or the clear sweep is running

Behaviour:
- Reset is synchronous and active-high (rst = 1 sampled at the clk edge). While rst = 1:
  - FSM forced to INIT; sweep pointer = 1.
  - init_busy = 1; rdata1 = rdata2 = 0.
- FSM states: INIT, READY.
  - INIT: each cycle writes 0 to reg[ptr], then ptr += 1. After writing ptr = 31, next state is READY.
  - Sweep takes 31 cycles after rst deasserts; init_busy drops on the cycle READY is entered.
  - READY is held until the next rst.
- reg[0] is never written and always reads 0.
- Write, READY only: if we = 1 and waddr != 0, reg[waddr] <= wdata at the clk edge.
  - During INIT or rst, external writes are ignored (dropped, not queued).
- Read port n (n = 1, 2) is combinational, priority in order:
  - rst = 1 or init_busy = 1 -> 0
  - ren = 0 -> 0
  - raddrn = 0 -> 0
  - we = 1, waddr = raddrn (nonzero) -> wdata (same-cycle write-through bypass)
  - otherwise -> reg[raddrn]
- Both ports may read the same address, with identical results.
- Simultaneous bypass on both ports is legal.
- rst asserted mid-sweep or in READY: the sweep restarts from r1 on the next cycle after rst deasserts.
- No X propagation from uninitialised storage reaches the outputs.

Optional Feature:
- Macro REGFILE_DBG_PORT_EN.
- Defined:
  - Adds ports dbg_addr (in, ADDR_W) and dbg_data (out, DATA_W).
  - dbg_data = reg[dbg_addr] combinational, no bypass.
  - dbg_data reads 0 for address 0, during rst, and during INIT.
- Undefined: the ports do not exist and there is no extra logic.

Decomposition:
- Shared package / defines.v: RegBus, RegAddrBus, RstEnable, WriteEnable, ReadEnable, ZeroWord, NOPRegAddr, RegNum.
- One sub-module, regfile_rd_port: a combinational read mux implementing the priority chain above, instantiated twice.
- Storage array, write logic and the INIT/READY FSM live in the top.

Test Plan:
- Reset + sweep: rst = 1 for 2 cycles, then 0.
  - init_busy = 1 for exactly 31 cycles after deassert, then 0.
  - Reading all 32 registers afterwards returns 0.
- Basic write/read: READY; we = 1, waddr = 5, wdata = 0xDEADBEEF.
  - Next cycle, re1 = 1, raddr1 = 5 -> rdata1 = 0xDEADBEEF.
  - re2 = 0 -> rdata2 = 0.
- Bypass: same cycle, we = 1, waddr = 7, wdata = 0x12345678; re1 = re2 = 1, raddr1 = raddr2 = 7.
  - Both outputs = 0x12345678 in that cycle, before the edge.
- Register zero: we = 1, waddr = 0, wdata = 0xFFFFFFFF; raddr1 = 0, re1 = 1.
  - rdata1 = 0 in that cycle and the next.
- Write during sweep: rst pulse, then on sweep cycle 3 drive we = 1, waddr = 20, wdata = 0xAA55AA55.
  - After READY, reg 20 reads 0 (write dropped).
- Mid-operation reset: write r9 = 0x1, assert rst for 1 cycle.
  - Sweep reruns (31 busy cycles), then r9 reads 0.
  - With REGFILE_DBG_PORT_EN defined, dbg_addr = 9 gives dbg_data = 0 during the sweep and after it.
